jk_ff_checker: RTL and testbench
================================

Name: jk_ff_checker

Overview:
- Self-checking response monitor for JK flip-flop banks; pairs with a stimulus generator on the other end of the J/K/Q interface.
- Samples J, K, Q and Qbar of a WIDTH-bit JK flip-flop bank on every rising Clk.
- Predicts the next Q from the characteristic equation Q+ = J&~Q | ~K&Q and compares it against the DUT.
- Reports an error pulse, a saturating error count, a check count and an overall pass flag; dropped next to any JK_FF-based DUT in lab benches.

Parameters:
WIDTH, 1, number of flip-flops observed in parallel.
CNT_W, 8, width of the error and check counters.
HALT_ON_ERR, 0, 1 = freeze checking after the first mismatch until reset.

Ports:
Clk  input  1  rising-edge clock, same clock as the DUT.
Reset  input  1  asynchronous, active-low reset.
En  input  1  checking enable; 0 suspends checking and forces a re-seed.
J  input  WIDTH  J inputs as driven to the DUT.
K  input  WIDTH  K inputs as driven to the DUT.
Q  input  WIDTH  DUT Q outputs.
Qbar  input  WIDTH  DUT Qbar outputs.
Err  output  1  one-cycle pulse, high in the cycle after a mismatching sample.
ErrCount  output  CNT_W  saturating count of mismatching samples.
CheckCount  output  CNT_W  saturating count of compared samples.
Pass  output  1  1 when CheckCount!=0 and ErrCount==0.
Halted  output  1  high in HALT state.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE, pred=0.
  - Err=0, ErrCount=0, CheckCount=0, Pass=0, Halted=0.
- Sampling: all inputs are sampled at the rising Clk. Q sampled at edge n+1 is the DUT response to J,K sampled at edge n.
- States: IDLE, CHECK, HALT.
- IDLE:
  - En=0: hold all state.
  - En=1: seed pred <= J&~Q | ~K&Q using the sampled Q. No compare, no count. Go to CHECK.
- CHECK with En=1, each edge:
  - mismatch = (Q!=pred) | (Qbar!=~Q), bitwise OR-reduced across WIDTH.
  - CheckCount++ on every compare.
  - On mismatch: ErrCount++ and Err=1 for the next cycle.
  - pred <= J&~Q | ~K&Q using the observed Q. This resyncs the model, so one DUT glitch counts as one error, not a cascade.
- CHECK with En=0: go to IDLE. Counters hold. The next En=1 re-seeds without comparing.
- HALT_ON_ERR=1 and a mismatch occurs:
  - The error is counted and Err pulses.
  - Next state is HALT.
- HALT:
  - Counters frozen, Err=0, Halted=1.
  - Exit only via Reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Pass is registered, combinational from counter values only; it drops the cycle after the first error is counted.
- X/Z on Q or Qbar counts as a mismatch; compare with !== semantics.
- Reset asserted mid-check: immediate return to reset values. The first edge after release with En=1 seeds only.
- Err in successive cycles for consecutive mismatches: Err stays high while every sample mismatches.

Optional Feature:
- Macro JK_CHK_FIRST_ERR_EN.
- Defined:
  - Adds outputs FirstErrCycle (CNT_W) and FirstErrMask (WIDTH).
  - On the first counted mismatch after reset, they capture CheckCount (pre-increment value) and the per-bit mismatch mask (Q^pred)|(Qbar^~Q).
  - They hold until Reset and reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset low at t=0, released at 1 ns; En=1, correct JK_FF DUT, J toggling every 150 ns, K every 75 ns, Clk period 200 ns, 4 edges -> ErrCount=0, CheckCount=3 (first edge seeds), Pass=1, Err never high.
- Correct DUT, J=1 K=1 for 6 edges -> Q toggles each edge; CheckCount=5, ErrCount=0.
- Faulty DUT with Q stuck at 0, J=1 K=0 -> Err high the cycle after edge 2; ErrCount increments each subsequent edge; Pass=0. Macro defined: FirstErrCycle=0, FirstErrMask=1.
- HALT_ON_ERR=1, single corrupted Qbar sample (Qbar==Q) at the 3rd compare -> ErrCount=1, Halted=1; later good and bad samples leave CheckCount=3, ErrCount=1.
- En dropped for 2 edges then raised with Q forced to an arbitrary value -> no error on the re-seed edge; checking resumes and counters are preserved.
- CNT_W=2, faulty DUT for 6 edges -> ErrCount saturates at 3 and CheckCount saturates at 3, with no wrap; Reset pulled low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/jk_ff_checker.sv
// rtl/jk_ff_checker.sv - response monitor for a WIDTH-bit JK flip-flop bank
//
// Samples J, K, Q and Qbar on every rising Clk, predicts the next Q from the
// JK characteristic equation and flags any response that disagrees.
//
// Ports:
//   Clk          rising-edge clock shared with the observed bank
//   Reset        asynchronous active-low reset
//   En           checking enable; 0 suspends checking and forces a re-seed
//   J, K         flip-flop inputs as driven to the bank (WIDTH)
//   Q, Qbar      flip-flop outputs from the bank (WIDTH)
//   Err          one-cycle pulse in the cycle after a mismatching sample
//   ErrCount     saturating count of mismatching samples (CNT_W)
//   CheckCount   saturating count of compared samples (CNT_W)
//   Pass         registered: CheckCount != 0 and ErrCount == 0
//   Halted       high while frozen after an error (HALT_ON_ERR = 1)
//
// Optional feature, macro JK_CHK_FIRST_ERR_EN:
//   FirstErrCycle  CheckCount value at the first counted mismatch (CNT_W)
//   FirstErrMask   per-bit mismatch mask of that sample (WIDTH)

module jk_ff_checker #(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 8,
    parameter int HALT_ON_ERR = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] Qbar,
    output logic             Err,
    output logic [CNT_W-1:0] ErrCount,
    output logic [CNT_W-1:0] CheckCount,
    output logic             Pass,
    output logic             Halted
`ifdef JK_CHK_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] FirstErrCycle,
    output logic [WIDTH-1:0] FirstErrMask
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pred;
    logic [WIDTH-1:0] pred_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [CNT_W-1:0] chk_cnt_nxt;
    logic             err_counted;

    logic [WIDTH-1:0] q_model;
    logic             mismatch;

    // Expected response to the J/K sampled at this edge, built from the Q
    // actually observed so that one glitch costs exactly one error.
    assign q_model = (J & ~Q) | (~K & Q);

    // Case-inequality so X/Z on Q or Qbar is reported as a mismatch.
    assign mismatch = (Q !== pred) || (Qbar !== ~Q);

    assign Halted = (state == ST_HALT);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pred_nxt    = pred;
        err_nxt     = 1'b0;
        err_cnt_nxt = ErrCount;
        chk_cnt_nxt = CheckCount;
        err_counted = 1'b0;

        case (state)
            ST_IDLE: begin
                // First enabled edge only seeds the prediction.
                if (En) begin
                    pred_nxt  = q_model;
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!En) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (CheckCount != CNT_MAX) begin
                        chk_cnt_nxt = CheckCount + CNT_W'(1);
                    end
                    if (mismatch) begin
                        err_nxt     = 1'b1;
                        err_counted = 1'b1;
                        if (ErrCount != CNT_MAX) begin
                            err_cnt_nxt = ErrCount + CNT_W'(1);
                        end
                        if (HALT_ON_ERR != 0) begin
                            state_nxt = ST_HALT;
                        end
                    end
                    pred_nxt = q_model;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pred       <= '0;
            Err        <= 1'b0;
            ErrCount   <= '0;
            CheckCount <= '0;
            Pass       <= 1'b0;
        end else begin
            pred       <= pred_nxt;
            Err        <= err_nxt;
            ErrCount   <= err_cnt_nxt;
            CheckCount <= chk_cnt_nxt;
            // Follows the counters one cycle late by design.
            Pass       <= (CheckCount != '0) && (ErrCount == '0);
        end
    end

`ifdef JK_CHK_FIRST_ERR_EN
    logic             first_seen;
    logic [WIDTH-1:0] mism_mask;

    assign mism_mask = (Q ^ pred) | (Qbar ^ ~Q);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            first_seen    <= 1'b0;
            FirstErrCycle <= '0;
            FirstErrMask  <= '0;
        end else if (err_counted && !first_seen) begin
            first_seen    <= 1'b1;
            FirstErrCycle <= CheckCount;
            FirstErrMask  <= mism_mask;
        end
    end
`endif

endmodule

// File: tb/tb_jk_ff_checker.sv
// tb/tb_jk_ff_checker.sv - randomized self-checking bench for jk_ff_checker

module tb_jk_ff_checker;

    localparam int W = 4;

    logic         Clk;
    logic         Reset;
    logic         En;
    logic [W-1:0] J, K, Q, Qbar;

    logic         err0, err1, err2;
    logic [7:0]   errc0, errc1, chkc0, chkc1;
    logic [1:0]   errc2, chkc2;
    logic         pass0, pass1, pass2;
    logic         halt0, halt1, halt2;
`ifdef JK_CHK_FIRST_ERR_EN
    logic [7:0]   fcyc0, fcyc1;
    logic [1:0]   fcyc2;
    logic [W-1:0] fmask0, fmask1, fmask2;
`endif

    // Three configurations observe the same bus: plain, halt-on-error, 2-bit counters.
    jk_ff_checker #(.WIDTH(W), .CNT_W(8), .HALT_ON_ERR(0)) u_plain (
        .Clk(Clk), .Reset(Reset), .En(En), .J(J), .K(K), .Q(Q), .Qbar(Qbar),
        .Err(err0), .ErrCount(errc0), .CheckCount(chkc0), .Pass(pass0), .Halted(halt0)
`ifdef JK_CHK_FIRST_ERR_EN
        , .FirstErrCycle(fcyc0), .FirstErrMask(fmask0)
`endif
    );

    jk_ff_checker #(.WIDTH(W), .CNT_W(8), .HALT_ON_ERR(1)) u_halt (
        .Clk(Clk), .Reset(Reset), .En(En), .J(J), .K(K), .Q(Q), .Qbar(Qbar),
        .Err(err1), .ErrCount(errc1), .CheckCount(chkc1), .Pass(pass1), .Halted(halt1)
`ifdef JK_CHK_FIRST_ERR_EN
        , .FirstErrCycle(fcyc1), .FirstErrMask(fmask1)
`endif
    );

    jk_ff_checker #(.WIDTH(W), .CNT_W(2), .HALT_ON_ERR(0)) u_sat (
        .Clk(Clk), .Reset(Reset), .En(En), .J(J), .K(K), .Q(Q), .Qbar(Qbar),
        .Err(err2), .ErrCount(errc2), .CheckCount(chkc2), .Pass(pass2), .Halted(halt2)
`ifdef JK_CHK_FIRST_ERR_EN
        , .FirstErrCycle(fcyc2), .FirstErrMask(fmask2)
`endif
    );

    logic [31:0] got_err [3];
    logic [31:0] got_errc[3];
    logic [31:0] got_chkc[3];
    logic [31:0] got_pass[3];
    logic [31:0] got_halt[3];
    assign got_err[0]  = 32'(err0);
    assign got_err[1]  = 32'(err1);
    assign got_err[2]  = 32'(err2);
    assign got_errc[0] = 32'(errc0);
    assign got_errc[1] = 32'(errc1);
    assign got_errc[2] = 32'(errc2);
    assign got_chkc[0] = 32'(chkc0);
    assign got_chkc[1] = 32'(chkc1);
    assign got_chkc[2] = 32'(chkc2);
    assign got_pass[0] = 32'(pass0);
    assign got_pass[1] = 32'(pass1);
    assign got_pass[2] = 32'(pass2);
    assign got_halt[0] = 32'(halt0);
    assign got_halt[1] = 32'(halt1);
    assign got_halt[2] = 32'(halt2);
`ifdef JK_CHK_FIRST_ERR_EN
    logic [31:0] got_fcyc [3];
    logic [31:0] got_fmask[3];
    assign got_fcyc[0]  = 32'(fcyc0);
    assign got_fcyc[1]  = 32'(fcyc1);
    assign got_fcyc[2]  = 32'(fcyc2);
    assign got_fmask[0] = 32'(fmask0);
    assign got_fmask[1] = 32'(fmask1);
    assign got_fmask[2] = 32'(fmask2);
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, one slot per instance. Mode: 0 waiting to seed,
    // 1 comparing, 2 frozen.
    int           m_max [3] = '{255, 255, 3};
    int           m_hlt [3] = '{0, 1, 0};
    int           m_mode[3];
    logic [W-1:0] m_pred[3];
    int           m_err [3];
    int           m_errc[3];
    int           m_chkc[3];
    int           m_pass[3];
    int           m_first[3];
    int           m_fcyc[3];
    logic [W-1:0] m_fmask[3];

    // Emulated healthy flip-flop bank state.
    logic [W-1:0] true_q;

    // Per-bit JK truth table: hold / reset / set / toggle.
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] j, input logic [W-1:0] k,
                                             input logic [W-1:0] q);
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) begin
            case ({j[b], k[b]})
                2'b00:   r[b] = q[b];
                2'b01:   r[b] = 1'b0;
                2'b10:   r[b] = 1'b1;
                default: r[b] = ~q[b];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_pred[i] = '0; m_err[i] = 0; m_errc[i] = 0;
            m_chkc[i] = 0; m_pass[i] = 0; m_first[i] = 0; m_fcyc[i] = 0; m_fmask[i] = '0;
        end
    endtask

    // Advances the model by one edge using the inputs currently on the bus.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] diff;
            int           new_pass;
            diff     = (Q ^ m_pred[i]) | (Qbar ^ ~Q);
            new_pass = (m_chkc[i] != 0 && m_errc[i] == 0) ? 1 : 0;
            m_err[i] = 0;
            if (m_mode[i] == 0) begin
                if (En) begin
                    m_pred[i] = jk_next(J, K, Q);
                    m_mode[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                if (!En) begin
                    m_mode[i] = 0;
                end else begin
                    if (diff != '0) begin
                        if (m_first[i] == 0) begin
                            m_first[i] = 1;
                            m_fcyc[i]  = m_chkc[i];
                            m_fmask[i] = diff;
                        end
                        m_errc[i] = (m_errc[i] + 1 > m_max[i]) ? m_max[i] : m_errc[i] + 1;
                        m_err[i]  = 1;
                        if (m_hlt[i] != 0) m_mode[i] = 2;
                    end
                    m_chkc[i] = (m_chkc[i] + 1 > m_max[i]) ? m_max[i] : m_chkc[i] + 1;
                    m_pred[i] = jk_next(J, K, Q);
                end
            end
            m_pass[i] = new_pass;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_err%0d", tag, i),  got_err[i],  32'(m_err[i]));
            check($sformatf("%s_errc%0d", tag, i), got_errc[i], 32'(m_errc[i]));
            check($sformatf("%s_chkc%0d", tag, i), got_chkc[i], 32'(m_chkc[i]));
            check($sformatf("%s_pass%0d", tag, i), got_pass[i], 32'(m_pass[i]));
            check($sformatf("%s_halt%0d", tag, i), got_halt[i], (m_mode[i] == 2) ? 32'd1 : 32'd0);
`ifdef JK_CHK_FIRST_ERR_EN
            check($sformatf("%s_fcyc%0d", tag, i),  got_fcyc[i],  32'(m_fcyc[i]));
            check($sformatf("%s_fmask%0d", tag, i), got_fmask[i], 32'(m_fmask[i]));
`endif
        end
    endtask

    // Called just after a falling edge; reset must take effect without a clock.
    task automatic do_reset();
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        #1;
        Reset = 1'b1;
    endtask

    task automatic cycle(input logic en_i, input logic [W-1:0] j_i, input logic [W-1:0] k_i,
                         input logic [W-1:0] q_i, input logic [W-1:0] qb_i);
        En = en_i; J = j_i; K = k_i; Q = q_i; Qbar = qb_i;
        model_step();
        true_q = jk_next(j_i, k_i, true_q);
        @(posedge Clk);
        @(negedge Clk);
        check_all("cyc");
    endtask

    task automatic good(input logic [W-1:0] j_i, input logic [W-1:0] k_i);
        cycle(1'b1, j_i, k_i, true_q, ~true_q);
    endtask

    initial begin
        Reset = 1'b0; En = 1'b0; J = '0; K = '0; Q = '0; Qbar = '1;
        true_q = '0;
        model_reset();
        @(negedge Clk);
        check_all("init");
        Reset = 1'b1;

        // Healthy bank, varying J/K: first edge seeds, three compares.
        good(4'h0, 4'h0);
        good(4'h0, 4'hF);
        good(4'hF, 4'hF);
        good(4'hF, 4'h0);
        check("basic_chk", got_chkc[0], 32'd3);
        check("basic_errc", got_errc[0], 32'd0);
        check("basic_pass", got_pass[0], 32'd1);

        // Toggle mode for six edges.
        do_reset();
        for (int n = 0; n < 6; n++) good(4'hF, 4'hF);
        check("toggle_chk", got_chkc[0], 32'd5);
        check("toggle_errc", got_errc[0], 32'd0);

        // Q stuck at 0 while J=1,K=0 demands 1: every compare fails.
        do_reset();
        for (int n = 0; n < 6; n++) cycle(1'b1, 4'hF, 4'h0, 4'h0, 4'hF);
        check("stuck_errc0", got_errc[0], 32'd5);
        check("stuck_pass0", got_pass[0], 32'd0);
        check("stuck_err0", got_err[0], 32'd1);
        check("sat_errc2", got_errc[2], 32'd3);
        check("sat_chkc2", got_chkc[2], 32'd3);
        check("stuck_halt1", got_halt[1], 32'd1);
        check("stuck_errc1", got_errc[1], 32'd1);
`ifdef JK_CHK_FIRST_ERR_EN
        check("stuck_fcyc0", got_fcyc[0], 32'd0);
        check("stuck_fmask0", got_fmask[0], 32'hF);
`endif

        // Corrupt Qbar on the third compare, then a mix of good and bad samples.
        do_reset();
        good(4'h3, 4'h5);
        good(4'hA, 4'h6);
        good(4'h1, 4'h8);
        cycle(1'b1, 4'h5, 4'h5, true_q, true_q);
        good(4'hC, 4'h3);
        cycle(1'b1, 4'hF, 4'h0, ~true_q, true_q);
        good(4'h0, 4'h0);
        check("halt_chk1", got_chkc[1], 32'd3);
        check("halt_errc1", got_errc[1], 32'd1);
        check("halt_flag1", got_halt[1], 32'd1);
        check("halt_err1", got_err[1], 32'd0);

        // Enable dropped, bank forced to an arbitrary value, then re-seed.
        do_reset();
        good(4'h6, 4'h9);
        good(4'hF, 4'h1);
        good(4'h2, 4'h4);
        cycle(1'b0, 4'h7, 4'h7, ~true_q, true_q);
        cycle(1'b0, 4'h1, 4'h2, true_q, true_q);
        true_q = 4'($urandom);
        good(4'h9, 4'h3);
        good(4'h5, 4'hA);
        good(4'hE, 4'hE);
        check("reseed_errc0", got_errc[0], 32'd0);
        check("reseed_chk0", got_chkc[0], 32'd4);

        // Randomized traffic with injected faults, enable gaps and resets.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            logic         en_r;
            logic [W-1:0] q_r, qb_r;
            int           r;
            if ($urandom_range(0, 59) == 0) do_reset();
            en_r = ($urandom_range(0, 9) != 0);
            q_r  = true_q;
            qb_r = ~true_q;
            r    = $urandom_range(0, 15);
            if (r == 0) q_r = q_r ^ (4'd1 << $urandom_range(0, W - 1));
            else if (r == 1) qb_r = q_r;
            cycle(en_r, 4'($urandom), 4'($urandom), q_r, qb_r);
        end

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
